ext_mem_responder: RTL and testbench
====================================

EXT_MEM_RESPONDER -- requirements
Module: ext_mem_responder

Interface
- REQ-001 Parameter WAIT_STATES, default 3, meaning extra wait cycles before ack (range 0..15).
- REQ-002 Parameter BASE_ADDR, default 32'h0000_0A00, meaning first byte address of the external window.
- REQ-003 Parameter DEPTH_WORDS, default 256, meaning 32-bit words in the window (0x0A00..0x0DFF).
- REQ-004 clk  input  1  sole clock, all state updates on rising edge.
- REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
- REQ-006 cs  input  1  chip select from the address decoder; 1 = external memory.
- REQ-007 req  input  1  initiator request strobe, sampled only in IDLE.
- REQ-008 we  input  1  1 = write, 0 = read; sampled with req.
- REQ-009 addr  input  32  byte address; sampled with req.
- REQ-010 wdata  input  32  write data; sampled with req.
- REQ-011 rdata  output  32  read data, registered, valid while ack=1 and held until next read completes.
- REQ-012 ack  output  1  one-cycle completion pulse.
- REQ-013 busy  output  1  high from acceptance until the cycle after ack.
- REQ-014 err  output  1  high with ack when the accepted address is outside the window.

Function
- REQ-015 FSM states SHALL be IDLE, WAIT, RESP.
- REQ-016 IDLE: accept when req=1 and cs=1 at a clock edge; capture we/addr/wdata; go to WAIT with counter=WAIT_STATES-1, or directly to RESP if WAIT_STATES=0.
- REQ-017 IDLE with req=1, cs=0: no acceptance, outputs unchanged.
- REQ-018 WAIT: decrement counter each cycle; go to RESP on the edge where counter=0.
- REQ-019 RESP: ack=1 for exactly one cycle; unconditional return to IDLE next edge.
- REQ-020 Latency: ack high exactly WAIT_STATES+1 cycles after the accepting edge.
- REQ-021 Word index = (addr - BASE_ADDR) >> 2; addr[1:0] ignored.
- REQ-022 In-window: addr >= BASE_ADDR and addr < BASE_ADDR + 4*DEPTH_WORDS; otherwise err=1 with ack, no write, rdata = 32'h0000_0000.
- REQ-023 Write: storage updated on the edge entering RESP; rdata unchanged.
- REQ-024 Read: rdata loaded on the edge entering RESP.
- REQ-025 req/cs/addr changes while busy=1 SHALL be ignored; no queuing.
- REQ-026 req held high through ack: new transaction accepted on the first IDLE edge after RESP (back-to-back, one idle cycle).
- REQ-027 busy=1 in WAIT and RESP, 0 in IDLE.

Reset
- REQ-028 rst_n=0 SHALL immediately force state IDLE, counter 0, ack=0, err=0, busy=0, rdata=0.
- REQ-029 Reset mid-transaction SHALL abort it: no ack, no storage write.
- REQ-030 Storage contents SHALL NOT be cleared by reset.
- REQ-031 First acceptance possible on the first rising edge after rst_n deasserts.

Structure
- REQ-032 Shared package ext_mem_pkg SHALL hold the state enum, EXT_BASE_ADDR (32'h0A00) and EXT_LIMIT_ADDR (32'h0DFF) constants shared with the address decoder.
- REQ-033 Storage SHALL be a sub-module ext_mem_array (synchronous write, registered read, DEPTH_WORDS x 32).

Verification
- REQ-034 Write 32'hDEAD_BEEF to 0x0A00, then read 0x0A00 -> rdata=32'hDEAD_BEEF, err=0, ack 4 cycles after each accept.
- REQ-035 Boundary: write/read 0x0DFC with 32'h1234_5678 -> correct data; read 0x0E00 and 0x09FC with cs forced 1 -> err=1, rdata=0.
- REQ-036 req=1 with cs=0 for 10 cycles -> busy=0, ack never asserted.
- REQ-037 rst_n pulsed low in WAIT of a write of 32'hCAFE_0001 to 0x0B00 -> no ack; subsequent read of 0x0B00 returns prior value.
- REQ-038 req held high, two reads 0x0C00, 0x0C04 -> two ack pulses separated by WAIT_STATES+2 cycles; changing addr while busy has no effect.
- REQ-039 WAIT_STATES=0 build: read accepted -> ack on the next cycle.

Source files
------------

// File: rtl/ext_mem_pkg.sv
// Shared definitions for the external memory window: address map constants,
// responder state encoding and the window membership helper.
package ext_mem_pkg;

  localparam logic [31:0] EXT_BASE_ADDR  = 32'h0000_0A00;
  localparam logic [31:0] EXT_LIMIT_ADDR = 32'h0000_0DFF;
  localparam int unsigned WAIT_CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Widened to 34 bits so a window ending at the top of the address space cannot wrap.
  function automatic logic addr_in_window(input logic [31:0] a,
                                          input logic [31:0] base,
                                          input int unsigned depth_words);
    logic [33:0] lim_end;
    lim_end = {2'b00, base} + {depth_words[31:0], 2'b00};
    return (a >= base) && ({2'b00, a} < lim_end);
  endfunction

endpackage

// File: rtl/ext_mem_array.sv
// Word storage for the external memory window: synchronous write, registered read.
module ext_mem_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned IDX_W       = 8
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic             i_rd_en,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // NOTE: storage has no reset on purpose; contents must survive rst_n and a
  // reset loop over the array would defeat RAM inference.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_idx] <= i_wdata;
    if (i_rd_en) r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ext_mem_responder.sv
// Wait-state memory responder: accepts one request at a time, holds it for
// WAIT_STATES cycles and completes it with a single-cycle ack.
module ext_mem_responder
  import ext_mem_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 3,
  parameter logic [31:0] BASE_ADDR   = EXT_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = int'((EXT_LIMIT_ADDR - EXT_BASE_ADDR + 32'd1) >> 2)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT =
    (WAIT_STATES == 0) ? '0 : WAIT_CNT_W'(WAIT_STATES - 1);

  state_t                r_state, w_state_nxt;
  logic [WAIT_CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic             r_we, r_in_win, r_rd_valid;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_wdata;

  logic             w_accept, w_in_win, w_enter_resp;
  logic             w_op_we, w_op_in_win, w_mem_wr, w_mem_rd;
  logic [IDX_W-1:0] w_idx, w_op_idx;
  logic [31:0]      w_op_wdata, w_mem_q;

  assign w_accept = (r_state == ST_IDLE) && req && cs;
  assign w_in_win = addr_in_window(addr, BASE_ADDR, DEPTH_WORDS);
  assign w_idx    = IDX_W'((addr - BASE_ADDR) >> 2);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (WAIT_STATES == 0) begin
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) w_state_nxt = ST_RESP;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_in_win <= 1'b0;
      r_idx    <= '0;
      r_wdata  <= '0;
    end else if (w_accept) begin
      r_we     <= we;
      r_in_win <= w_in_win;
      r_idx    <= w_idx;
      r_wdata  <= wdata;
    end
  end

  // With zero wait states RESP is entered on the accepting edge, so the
  // operation must come straight from the inputs rather than the capture regs.
  assign w_enter_resp = (w_state_nxt == ST_RESP);
  assign w_op_we      = (r_state == ST_IDLE) ? we       : r_we;
  assign w_op_in_win  = (r_state == ST_IDLE) ? w_in_win : r_in_win;
  assign w_op_idx     = (r_state == ST_IDLE) ? w_idx    : r_idx;
  assign w_op_wdata   = (r_state == ST_IDLE) ? wdata    : r_wdata;

  assign w_mem_wr = w_enter_resp &&  w_op_we && w_op_in_win;
  assign w_mem_rd = w_enter_resp && !w_op_we && w_op_in_win;

  // Selects between the array's read register and zero; only changes when a
  // read or an out-of-window access completes, so rdata holds across writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
    end else if (w_enter_resp && !(w_op_we && w_op_in_win)) begin
      r_rd_valid <= w_op_in_win;
    end
  end

  ext_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk    (clk),
    .i_wr_en(w_mem_wr),
    .i_rd_en(w_mem_rd),
    .i_idx  (w_op_idx),
    .i_wdata(w_op_wdata),
    .o_rdata(w_mem_q)
  );

  assign rdata = r_rd_valid ? w_mem_q : '0;
  assign ack   = (r_state == ST_RESP);
  assign busy  = (r_state != ST_IDLE);
  assign err   = ack && !r_in_win;

endmodule

// File: tb/tb_ext_mem_responder.sv
// Self-checking bench: a 3-wait-state responder (A) and a zero-wait-state one (B)
// compared against an array-based model of the memory window.
module tb_ext_mem_responder;

  localparam int          WS_A   = 3;
  localparam logic [31:0] WIN_LO = 32'h0000_0A00;
  localparam logic [31:0] WIN_HI = 32'h0000_0DFF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic        a_cs = 1'b0, a_req = 1'b0, a_we = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0;
  logic [31:0] a_rdata;
  logic        a_ack, a_busy, a_err;

  logic        b_cs = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [31:0] b_addr = '0, b_wdata = '0;
  logic [31:0] b_rdata;
  logic        b_ack, b_busy, b_err;

  always #5 clk = ~clk;

  ext_mem_responder #(.WAIT_STATES(WS_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .cs(a_cs), .req(a_req), .we(a_we), .addr(a_addr),
    .wdata(a_wdata), .rdata(a_rdata), .ack(a_ack), .busy(a_busy), .err(a_err)
  );

  ext_mem_responder #(.WAIT_STATES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .cs(b_cs), .req(b_req), .we(b_we), .addr(b_addr),
    .wdata(b_wdata), .rdata(b_rdata), .ack(b_ack), .busy(b_busy), .err(b_err)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] mdl_mem   [2][256];
  bit          mdl_vld   [2][256];
  logic [31:0] mdl_rdata [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return (a >= WIN_LO) && (a <= WIN_HI);
  endfunction

  function automatic logic get_ack(input bit sel);
    return sel ? b_ack : a_ack;
  endfunction

  function automatic logic get_busy(input bit sel);
    return sel ? b_busy : a_busy;
  endfunction

  task automatic drive(input bit sel, input logic r, input logic c, input logic w,
                       input logic [31:0] ad, input logic [31:0] wd);
    if (sel) begin
      b_req = r; b_cs = c; b_we = w; b_addr = ad; b_wdata = wd;
    end else begin
      a_req = r; a_cs = c; a_we = w; a_addr = ad; a_wdata = wd;
    end
  endtask

  // One transaction: present at negedge, accept at posedge, scramble inputs
  // while busy, wait (bounded) for ack, then confirm the pulse and busy drop.
  task automatic txn(input bit sel, input bit t_we, input logic [31:0] t_addr,
                     input logic [31:0] t_wdata, input string tag,
                     output int lat, output logic [31:0] rd, output logic e);
    @(negedge clk);
    drive(sel, 1'b1, 1'b1, t_we, t_addr, t_wdata);
    @(posedge clk); #1;
    check({tag, "_busy_acc"}, 32'(get_busy(sel)), 32'd1);
    drive(sel, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
    lat = 1;
    while (!get_ack(sel) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = sel ? b_rdata : a_rdata;
    e  = sel ? b_err   : a_err;
    @(posedge clk); #1;
    check({tag, "_ack_pulse"}, 32'(get_ack(sel)), 32'd0);
    check({tag, "_busy_end"},  32'(get_busy(sel)), 32'd0);
  endtask

  task automatic do_check(input bit sel, input bit t_we, input logic [31:0] t_addr,
                          input logic [31:0] t_wdata, input string tag);
    int          lat;
    logic [31:0] rd;
    logic        e;
    int          ws;
    int          idx;
    bit          iw;
    bit          known;
    ws    = sel ? 0 : WS_A;
    iw    = in_win(t_addr);
    idx   = int'((t_addr - WIN_LO) >> 2);
    known = 1'b1;
    txn(sel, t_we, t_addr, t_wdata, tag, lat, rd, e);
    if (!iw) begin
      mdl_rdata[sel] = '0;
    end else if (t_we) begin
      mdl_mem[sel][idx] = t_wdata;
      mdl_vld[sel][idx] = 1'b1;
    end else begin
      known          = mdl_vld[sel][idx];
      mdl_rdata[sel] = mdl_mem[sel][idx];
    end
    check({tag, "_latency"}, 32'(lat), 32'(ws + 1));
    check({tag, "_err"}, 32'(e), 32'(!iw));
    if (known) check({tag, "_rdata"}, rd, mdl_rdata[sel]);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t1, t2, lat, n_busy, n_ack, idx, r;
    logic [31:0] rd1, rd2, ad;
    logic        gap_busy;
    bit          sel, w;

    mdl_rdata[0] = '0;
    mdl_rdata[1] = '0;

    // Reset values while rst_n is held low.
    #12;
    check("rst_rdata", a_rdata, 32'h0);
    check("rst_ack",   32'(a_ack),  32'd0);
    check("rst_busy",  32'(a_busy), 32'd0);
    check("rst_err",   32'(a_err),  32'd0);
    check("rst_b_rdata", b_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write/read at the window base.
    do_check(0, 1'b1, 32'h0A00, 32'hDEAD_BEEF, "wr_0a00");
    do_check(0, 1'b0, 32'h0A00, 32'h0,         "rd_0a00");

    // Window boundaries, byte-offset aliasing and out-of-window accesses.
    do_check(0, 1'b1, 32'h0DFC, 32'h1234_5678, "wr_0dfc");
    do_check(0, 1'b0, 32'h0DFC, 32'h0,         "rd_0dfc");
    do_check(0, 1'b0, 32'h0E00, 32'h0,         "rd_0e00");
    do_check(0, 1'b0, 32'h0DFF, 32'h0,         "rd_0dff");
    do_check(0, 1'b0, 32'h09FC, 32'h0,         "rd_09fc");
    do_check(0, 1'b1, 32'h0E00, 32'hBAD0_BAD0, "wr_0e00");

    // Requests without chip select are never accepted and cannot write.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 1'b1, 32'h0A00, 32'hFFFF_FFFF);
    n_busy = 0;
    n_ack  = 0;
    repeat (10) begin
      @(posedge clk); #1;
      n_busy += int'(a_busy);
      n_ack  += int'(a_ack);
      a_addr = $urandom;
    end
    check("nocs_busy_cycles", 32'(n_busy), 32'd0);
    check("nocs_ack_cycles",  32'(n_ack),  32'd0);
    check("nocs_rdata_held",  a_rdata, mdl_rdata[0]);
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    do_check(0, 1'b0, 32'h0A00, 32'h0, "rd_after_nocs");

    // Back-to-back reads with req held; input changes while busy are ignored.
    do_check(0, 1'b1, 32'h0C00, 32'hA5A5_0C00, "wr_0c00");
    do_check(0, 1'b1, 32'h0C04, 32'h5A5A_0C04, "wr_0c04");
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 1'b0, 32'h0C00, 32'h0);
    @(posedge clk); #1;
    t1 = -1; t2 = -1; gap_busy = 1'b1; rd1 = '0; rd2 = '0;
    for (int n = 1; n <= 40 && t2 < 0; n++) begin
      if (t1 < 0) begin
        a_addr = $urandom;
        a_cs   = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      if (t1 >= 0 && n == t1 + 1) gap_busy = a_busy;
      if (a_ack) begin
        if (t1 < 0) begin
          t1 = n; rd1 = a_rdata; a_addr = 32'h0C04; a_cs = 1'b1;
        end else begin
          t2 = n; rd2 = a_rdata; a_req = 1'b0;
        end
      end
    end
    check("b2b_first_lat", 32'(t1), 32'(WS_A));
    check("b2b_ack_gap",   32'(t2 - t1), 32'(WS_A + 2));
    check("b2b_rdata1",    rd1, mdl_mem[0][(32'h0C00 - WIN_LO) >> 2]);
    check("b2b_rdata2",    rd2, mdl_mem[0][(32'h0C04 - WIN_LO) >> 2]);
    check("b2b_idle_busy", 32'(gap_busy), 32'd0);
    mdl_rdata[0] = mdl_mem[0][(32'h0C04 - WIN_LO) >> 2];
    @(posedge clk); #1;
    check("b2b_no_third", 32'(a_ack), 32'd0);
    @(posedge clk); #1;
    check("b2b_no_third2", 32'(a_busy), 32'd0);

    // Reset during WAIT aborts a write; acceptance on the first edge after release.
    do_check(0, 1'b1, 32'h0B00, 32'h1111_2222, "wr_0b00");
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 1'b1, 32'h0B00, 32'hCAFE_0001);
    @(posedge clk); #1;
    check("abort_busy_acc", 32'(a_busy), 32'd1);
    a_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(a_busy), 32'd0);
    check("abort_ack",  32'(a_ack),  32'd0);
    check("abort_rdata", a_rdata, 32'h0);
    check("abort_err",  32'(a_err),  32'd0);
    mdl_rdata[0] = '0;
    mdl_rdata[1] = '0;
    drive(0, 1'b1, 1'b1, 1'b0, 32'h0B00, 32'h0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_accept", 32'(a_busy), 32'd1);
    a_req = 1'b0;
    lat = 1;
    while (!a_ack && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("post_rst_lat",   32'(lat), 32'(WS_A + 1));
    check("post_rst_rdata", a_rdata, 32'h1111_2222);
    check("post_rst_err",   32'(a_err), 32'd0);
    mdl_rdata[0] = 32'h1111_2222;
    @(posedge clk); #1;

    // Zero-wait-state build.
    do_check(1, 1'b1, 32'h0A10, 32'h0BAD_F00D, "b_wr_0a10");
    do_check(1, 1'b0, 32'h0A10, 32'h0,         "b_rd_0a10");
    do_check(1, 1'b0, 32'h0E00, 32'h0,         "b_rd_0e00");

    // Randomized mix against the model on both builds.
    for (int i = 0; i < 60; i++) begin
      sel = (i >= 45);
      r   = int'($urandom_range(0, 9));
      idx = int'($urandom_range(0, 255));
      if (r < 2) begin
        w = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 2))
          0:       ad = $urandom_range(0, 32'h09FF);
          1:       ad = $urandom_range(32'h0E00, 32'h0001_0000);
          default: ad = $urandom | 32'h8000_0000;
        endcase
      end else begin
        w  = (r < 5) || !mdl_vld[sel][idx];
        ad = WIN_LO + 32'(idx * 4) + $urandom_range(0, 3);
      end
      do_check(sel, w, ad, $urandom, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
